// File: rtl/sap_1_pkg.sv
// sap_1_pkg: shared opcodes, control-word bit positions/masks and T-state encodings for the SAP-1 controller.
// Control word layout [11:0] = {Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, SU, EU, LBbar, LObar}.
package sap_1_pkg;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CB_CP = 11;
    localparam int CB_EP = 10;
    localparam int CB_LM = 9;
    localparam int CB_CE = 8;
    localparam int CB_LI = 7;
    localparam int CB_EI = 6;
    localparam int CB_LA = 5;
    localparam int CB_EA = 4;
    localparam int CB_SU = 3;
    localparam int CB_EU = 2;
    localparam int CB_LB = 1;
    localparam int CB_LO = 0;

    // Activating a signal means flipping its bit away from the idle level,
    // so every control word is CTRL_IDLE XOR a set of these masks.
    localparam logic [11:0] M_CP = 12'(1) << CB_CP;
    localparam logic [11:0] M_EP = 12'(1) << CB_EP;
    localparam logic [11:0] M_LM = 12'(1) << CB_LM;
    localparam logic [11:0] M_CE = 12'(1) << CB_CE;
    localparam logic [11:0] M_LI = 12'(1) << CB_LI;
    localparam logic [11:0] M_EI = 12'(1) << CB_EI;
    localparam logic [11:0] M_LA = 12'(1) << CB_LA;
    localparam logic [11:0] M_EA = 12'(1) << CB_EA;
    localparam logic [11:0] M_SU = 12'(1) << CB_SU;
    localparam logic [11:0] M_EU = 12'(1) << CB_EU;
    localparam logic [11:0] M_LB = 12'(1) << CB_LB;
    localparam logic [11:0] M_LO = 12'(1) << CB_LO;

    localparam logic [11:0] CTRL_IDLE = 12'h3E3;

    localparam logic [5:0] T_1 = 6'b000001;
    localparam logic [5:0] T_2 = 6'b000010;
    localparam logic [5:0] T_3 = 6'b000100;
    localparam logic [5:0] T_4 = 6'b001000;
    localparam logic [5:0] T_5 = 6'b010000;
    localparam logic [5:0] T_6 = 6'b100000;
    localparam logic [5:0] T_HALT = 6'b000000;
endpackage

// File: rtl/sap_1_control_decode.sv
// sap_1_control_decode: combinational control-word decode from T-state and opcode.
// Ports: en (1 = emit active word, else idle), t (one-hot T-state), op (effective opcode), control (12-bit word).
module sap_1_control_decode
    import sap_1_pkg::*;
(
    input  logic        en,
    input  logic [5:0]  t,
    input  logic [3:0]  op,
    output logic [11:0] control
);
    logic        lda, add, sub, out, alu;
    logic [11:0] mask;

    assign lda = op == OP_LDA;
    assign add = op == OP_ADD;
    assign sub = op == OP_SUB;
    assign out = op == OP_OUT;
    assign alu = add | sub;

    assign mask = !en ? 12'h000 :
                  t[0] ? (M_EP | M_LM) :
                  t[1] ? M_CP :
                  t[2] ? (M_CE | M_LI) :
                  t[3] ? ((lda | alu) ? (M_LM | M_EI) : out ? (M_EA | M_LO) : 12'h000) :
                  t[4] ? (lda ? (M_CE | M_LA) : alu ? (M_CE | M_LB) : 12'h000) :
                  t[5] ? (alu ? (M_LA | M_EU | (sub ? M_SU : 12'h000)) : 12'h000) :
                  12'h000;

    assign control = CTRL_IDLE ^ mask;
endmodule

// File: rtl/sap_1_controller_sequencer.sv
// sap_1_controller_sequencer: SAP-1 ring counter, halt, single-step, opcode latch and instruction counter.
// Ports: CLK, CLR (sync active-high), RUN, STEP, OPCODE in; CONTROL, ring_counter, HLT, INSTR_CNT out.
module sap_1_controller_sequencer
    import sap_1_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             RUN,
    input  logic             STEP,
    input  logic [3:0]       OPCODE,
    output logic [11:0]      CONTROL,
    output logic [5:0]       ring_counter,
    output logic             HLT,
    output logic [CNT_W-1:0] INSTR_CNT
);
    logic       step_q;
    logic [3:0] op_q;
    logic       advance;
    logic [3:0] op_eff;

    assign advance = RUN | (STEP & ~step_q);
    // The IR is only guaranteed stable during T4; later states use the copy taken leaving T4.
    assign op_eff = ring_counter[3] ? OPCODE : op_q;

    // Idle whenever no edge will consume the word, so held states never repeat Cp or loads.
    sap_1_control_decode u_decode (
        .en      (advance & ~CLR & ~HLT),
        .t       (ring_counter),
        .op      (op_eff),
        .control (CONTROL)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            ring_counter <= T_1;
            HLT          <= 1'b0;
            INSTR_CNT    <= '0;
            op_q         <= OP_LDA;
            step_q       <= 1'b0;
        end else begin
            step_q <= STEP;
            if (advance && !HLT) begin
                if (ring_counter[3])
                    op_q <= OPCODE;
                if (ring_counter[3] && OPCODE == OP_HLT) begin
                    ring_counter <= T_HALT;
                    HLT          <= 1'b1;
                end else begin
                    ring_counter <= {ring_counter[4:0], ring_counter[5]};
                end
                if (ring_counter[5])
                    INSTR_CNT <= INSTR_CNT + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// tb_sap_1_controller_sequencer: scoreboard bench; driver queues per-cycle expectations, monitor checks them at negedge.
module tb_sap_1_controller_sequencer;
    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        RUN = 1'b0;
    logic        STEP = 1'b0;
    logic [3:0]  OPCODE = 4'h0;
    logic [11:0] CONTROL;
    logic [5:0]  ring_counter;
    logic        HLT;
    logic [1:0]  INSTR_CNT;

    typedef struct {
        logic [11:0] c;
        logic [5:0]  r;
        logic        h;
        logic [1:0]  n;
        bit          st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   idx = 0;

    sap_1_controller_sequencer #(.CNT_W(2)) dut (
        .CLK          (CLK),
        .CLR          (CLR),
        .RUN          (RUN),
        .STEP         (STEP),
        .OPCODE       (OPCODE),
        .CONTROL      (CONTROL),
        .ring_counter (ring_counter),
        .HLT          (HLT),
        .INSTR_CNT    (INSTR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s item %0d got %h want %h", nm, idx, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("control", CONTROL, e.c);
                if (e.st) begin
                    chk("ring", {6'h0, ring_counter}, {6'h0, e.r});
                    chk("hlt", {11'h0, HLT}, {11'h0, e.h});
                    chk("instr_cnt", {10'h0, INSTR_CNT}, {10'h0, e.n});
                end
                idx++;
            end
        end
    end

    task automatic cyc(input logic clr, input logic run, input logic step, input logic [3:0] op,
                       input logic [11:0] c, input logic [5:0] r, input logic h, input logic [1:0] n,
                       input bit st = 1'b1);
        exp_t e;
        CLR = clr;
        RUN = run;
        STEP = step;
        OPCODE = op;
        e.c = c;
        e.r = r;
        e.h = h;
        e.n = n;
        e.st = st;
        q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic instr(input logic [3:0] op, input logic [3:0] op5, input logic [11:0] c4,
                         input logic [11:0] c5, input logic [11:0] c6, input logic [1:0] n);
        cyc(1'b0, 1'b1, 1'b0, op,  12'h5E3, 6'h01, 1'b0, n);
        cyc(1'b0, 1'b1, 1'b0, op,  12'hBE3, 6'h02, 1'b0, n);
        cyc(1'b0, 1'b1, 1'b0, op,  12'h263, 6'h04, 1'b0, n);
        cyc(1'b0, 1'b1, 1'b0, op,  c4,      6'h08, 1'b0, n);
        cyc(1'b0, 1'b1, 1'b0, op5, c5,      6'h10, 1'b0, n);
        cyc(1'b0, 1'b1, 1'b0, op5, c6,      6'h20, 1'b0, n);
    endtask

    initial begin : driver
        @(posedge CLK);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 4'h0, 12'h3E3, 6'h00, 1'b0, 2'd0, 1'b0);
        // LDA, then a hold cycle showing the count
        instr(4'h0, 4'h0, 12'h1A3, 12'h2C3, 12'h3E3, 2'd0);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 12'h3E3, 6'h01, 1'b0, 2'd1);
        // SUB with OPCODE moved to ADD in T5, then a real ADD
        instr(4'h2, 4'h1, 12'h1A3, 12'h2E1, 12'h3CF, 2'd1);
        instr(4'h1, 4'h1, 12'h1A3, 12'h2E1, 12'h3C7, 2'd2);
        // single-step: held STEP gives one advance
        cyc(1'b0, 1'b0, 1'b1, 4'h0, 12'h5E3, 6'h01, 1'b0, 2'd3);
        repeat (4) cyc(1'b0, 1'b0, 1'b1, 4'h0, 12'h3E3, 6'h02, 1'b0, 2'd3);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 12'h3E3, 6'h02, 1'b0, 2'd3);
        cyc(1'b0, 1'b0, 1'b1, 4'h0, 12'hBE3, 6'h02, 1'b0, 2'd3);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 12'h3E3, 6'h04, 1'b0, 2'd3);
        // RUN and STEP edge together: one advance
        cyc(1'b0, 1'b1, 1'b1, 4'h0, 12'h263, 6'h04, 1'b0, 2'd3);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 12'h3E3, 6'h08, 1'b0, 2'd3);
        // HLT at T4: halted, not counted, sticky under RUN/STEP
        cyc(1'b0, 1'b1, 1'b0, 4'hF, 12'h3E3, 6'h08, 1'b0, 2'd3);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, i[0], i[1], 4'h0, 12'h3E3, 6'h00, 1'b1, 2'd3);
        cyc(1'b1, 1'b1, 1'b1, 4'h0, 12'h3E3, 6'h00, 1'b1, 2'd3);
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 12'h3E3, 6'h01, 1'b0, 2'd0);
        // five OUTs: counter wraps 0,1,2,3,0 then 1
        for (int i = 0; i < 5; i++)
            instr(4'hE, 4'hE, 12'h3F2, 12'h3E3, 12'h3E3, 2'(i));
        cyc(1'b0, 1'b0, 1'b0, 4'h0, 12'h3E3, 6'h01, 1'b0, 2'd1);
        // CLR during T5 of ADD: word idle, instruction abandoned
        cyc(1'b0, 1'b1, 1'b0, 4'h1, 12'h5E3, 6'h01, 1'b0, 2'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'h1, 12'hBE3, 6'h02, 1'b0, 2'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'h1, 12'h263, 6'h04, 1'b0, 2'd1);
        cyc(1'b0, 1'b1, 1'b0, 4'h1, 12'h1A3, 6'h08, 1'b0, 2'd1);
        cyc(1'b1, 1'b1, 1'b0, 4'h1, 12'h3E3, 6'h10, 1'b0, 2'd1);
        cyc(1'b0, 1'b0, 1'b0, 4'h1, 12'h3E3, 6'h01, 1'b0, 2'd0);
        cyc(1'b0, 1'b1, 1'b0, 4'h1, 12'h5E3, 6'h01, 1'b0, 2'd0);
        RUN = 1'b0;
        repeat (5) begin
            if (q.size() == 0) break;
            @(negedge CLK);
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sap_1_controller_sequencer.md
Name: sap_1_controller_sequencer

Overview:
Clocked controller-sequencer for the SAP-1 datapath. It owns the 6-state ring counter (T1..T6), the instruction-decode flags and halt handling. It emits the 12-bit control word that drives the program counter, MAR, RAM, IR, accumulator, ALU, B and output registers. It also supports free-run and single-step modes and counts completed instructions.

Parameters:
CNT_W, 8, width of the completed-instruction counter INSTR_CNT

Ports:
CLK  input  1  system clock; all state updates on the rising edge
CLR  input  1  synchronous, active-high reset
RUN  input  1  1 = advance one T-state per cycle
STEP  input  1  single-step request; each 0->1 transition advances exactly one T-state
OPCODE  input  4  upper nibble of the instruction register
CONTROL  output  12  {Cp, Ep, LMbar, CEbar, LIbar, EIbar, LAbar, EA, SU, EU, LBbar, LObar}
ring_counter  output  6  [6:1], one-hot T-state; all zeros when halted
HLT  output  1  1 = halted
INSTR_CNT  output  CNT_W  number of completed instructions, modulo 2^CNT_W

Behaviour:
- Interface: one clock, CLK. Reset is synchronous and active-high, CLR.
- Opcodes: LDA=4'h0, ADD=4'h1, SUB=4'h2, OUT=4'hE, HLT=4'hF. All other opcodes are NOP: idle in T4..T6.
- Reset (CLR=1 at a rising edge):
  - ring_counter=6'b000001 (T1), HLT=0, INSTR_CNT=0.
  - Latched opcode = 4'h0; step-edge register = 0.
  - CLR dominates RUN and STEP. A mid-instruction CLR abandons the instruction without counting it.
  - While CLR=1, CONTROL is forced to idle combinationally.
- Idle word: CONTROL=12'h3E3 (all active-low bits 1, all active-high bits 0).
- advance = RUN | (STEP & ~step_q). step_q registers STEP every cycle.
  - RUN and a STEP edge in the same cycle produce a single advance.
  - STEP held high produces one advance only.
- CONTROL:
  - When advance=0, CLR=1 or HLT=1: CONTROL=12'h3E3. This prevents repeated Cp or loads while holding.
  - Otherwise CONTROL is decoded combinationally from the current T-state. In T4 it uses the live OPCODE; in T5/T6 it uses the opcode latched at T4.
- Control words:
  - T1=12'h5E3 (Ep, LMbar), T2=12'hBE3 (Cp), T3=12'h263 (CEbar, LIbar).
  - LDA: T4=1A3, T5=2C3, T6=3E3.
  - ADD: T4=1A3, T5=2E1, T6=3C7.
  - SUB: T4=1A3, T5=2E1, T6=3CF.
  - OUT: T4=3F2, T5=3E3, T6=3E3.
  - HLT and NOP: T4..T6=3E3.
- Transitions on a rising edge with advance=1:
  - Tn -> Tn+1 for n=1..5.
  - T6 -> T1, and INSTR_CNT increments, wrapping from all-ones to 0.
  - Leaving T4 latches OPCODE.
  - T4 with OPCODE=HLT -> HALTED: ring_counter=0, HLT=1. The instruction is not counted.
- HALTED is sticky. RUN and STEP are ignored; only CLR exits it.
- Registers in the datapath sample CONTROL on the same rising edge that advances the T-state. The IR loads at the end of T3, so OPCODE is valid throughout T4.
- OPCODE changes during T5/T6 have no effect on CONTROL.

Decomposition:
- Shared package sap_1_pkg:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - control-bit index constants;
  - CTRL_IDLE=12'h3E3;
  - T-state one-hot constants.
- The control-word decode is a natural sub-module: sap_1_control_decode, purely combinational (T-state, opcode flags -> CONTROL).
- The sequencer keeps the ring counter, halt, step-edge, opcode-latch and counter logic.

Test Plan:
- CLR=1 for 1 cycle, then RUN=1 with OPCODE=0 (LDA) valid from T4 -> CONTROL sequence 5E3, BE3, 263, 1A3, 2C3, 3E3. ring_counter 01,02,04,08,10,20. INSTR_CNT=1 after the T6 edge.
- RUN=1 with OPCODE=2 (SUB), OPCODE changed to 1 during T5 -> T6 CONTROL=3CF (latched SUB, not ADD). OPCODE=1 for the next instruction -> T6=3C7.
- RUN=0, STEP held high for 5 cycles then low -> exactly one T-state advance. CONTROL=3E3 on every non-advance cycle.
- OPCODE=F at T4 with RUN=1 -> next cycle HLT=1, ring_counter=0, CONTROL=3E3. It stays halted for 20 cycles of RUN/STEP. CLR then returns to T1 with HLT=0 and INSTR_CNT=0.
- CNT_W=2, run 5 OUT instructions -> T4 CONTROL=3F2 each time. INSTR_CNT goes 1,2,3,0,1.
- CLR asserted during T5 of ADD -> next cycle ring_counter=01, INSTR_CNT unchanged-to-0, no LBbar pulse after CLR.
